// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: read-return tags and port indices.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_VGA  = 2'd2
  } ret_tag_e;

  localparam logic [1:0] PORT_CPU = 2'd0;
  localparam logic [1:0] PORT_VGA = 2'd1;
  localparam logic [1:0] PORT_USR = 2'd2;

  localparam logic RR_CPU = 1'b0;
  localparam logic RR_USR = 1'b1;

endpackage

// File: rtl/dmem_arbiter_age.sv
// Saturating wait counter: counts denied cycles of a held request and flags
// the port as aged once STARVE denials have accumulated.
module arb_age_counter #(
  parameter int unsigned STARVE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic aged
);

  localparam logic [7:0] STARVE_C = 8'(STARVE);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: clear on grant or withdrawn request, otherwise saturate upward
  always_comb begin
    count_d = count_q;
    if (!req || gnt) begin
      count_d = 8'd0;
    end else if (count_q < STARVE_C) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Qualified by req so a stale saturated count never wins a withdrawn request.
  assign aged = req && (count_q == STARVE_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter for cpu, display (vga) and user-board ports.
// Display has priority; aged cpu/usr requests override it; cpu/usr share round-robin.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned AWIDTH = 16,
  parameter int unsigned STARVE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0]  cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [WIDTH-1:0]  cpu_rdata,
  input  logic              vga_req,
  input  logic [AWIDTH-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [WIDTH-1:0]  vga_rdata,
  input  logic              usr_req,
  input  logic [AWIDTH-1:0] usr_addr,
  input  logic [WIDTH-1:0]  usr_wdata,
  output logic              usr_gnt,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata
);

  logic     rr_q, rr_d;
  ret_tag_e tag_q, tag_d;
  logic     cpu_aged, usr_aged;
  logic     sel_vld;
  logic [1:0] sel_port;

  arb_age_counter #(.STARVE(STARVE)) u_cpu_age (
    .clk(clk), .rst(rst), .req(cpu_req), .gnt(cpu_gnt), .aged(cpu_aged)
  );

  arb_age_counter #(.STARVE(STARVE)) u_usr_age (
    .clk(clk), .rst(rst), .req(usr_req), .gnt(usr_gnt), .aged(usr_aged)
  );

  // Winner selection in priority order: aged cpu/usr, vga, round-robin cpu/usr
  always_comb begin
    sel_vld  = 1'b0;
    sel_port = PORT_CPU;
    if (rst) begin
      sel_vld = 1'b0;
    end else if (cpu_aged && usr_aged) begin
      sel_vld  = 1'b1;
      sel_port = (rr_q == RR_USR) ? PORT_USR : PORT_CPU;
    end else if (cpu_aged) begin
      sel_vld  = 1'b1;
      sel_port = PORT_CPU;
    end else if (usr_aged) begin
      sel_vld  = 1'b1;
      sel_port = PORT_USR;
    end else if (vga_req) begin
      sel_vld  = 1'b1;
      sel_port = PORT_VGA;
    end else if (cpu_req && usr_req) begin
      sel_vld  = 1'b1;
      sel_port = (rr_q == RR_USR) ? PORT_USR : PORT_CPU;
    end else if (cpu_req) begin
      sel_vld  = 1'b1;
      sel_port = PORT_CPU;
    end else if (usr_req) begin
      sel_vld  = 1'b1;
      sel_port = PORT_USR;
    end else begin
      sel_vld = 1'b0;
    end
  end

  // Grant decode, memory mux and next-state for rr pointer and return tag
  always_comb begin
    cpu_gnt   = 1'b0;
    vga_gnt   = 1'b0;
    usr_gnt   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rr_d      = rr_q;
    tag_d     = TAG_NONE;
    if (sel_vld) begin
      case (sel_port)
        PORT_CPU: begin
          cpu_gnt   = 1'b1;
          mem_we    = cpu_we;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          rr_d      = RR_USR;
          tag_d     = cpu_we ? TAG_NONE : TAG_CPU;
        end
        PORT_VGA: begin
          vga_gnt  = 1'b1;
          mem_addr = vga_addr;
          tag_d    = TAG_VGA;
        end
        PORT_USR: begin
          usr_gnt   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = usr_addr;
          mem_wdata = usr_wdata;
          rr_d      = RR_CPU;
        end
        default: begin
          tag_d = TAG_NONE;
        end
      endcase
    end else begin
      tag_d = TAG_NONE;
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q  <= RR_CPU;
      tag_q <= TAG_NONE;
    end else begin
      rr_q  <= rr_d;
      tag_q <= tag_d;
    end
  end

  // A reset landing in the return cycle drops the pending read data.
  assign cpu_rvalid = (tag_q == TAG_CPU) && !rst;
  assign vga_rvalid = (tag_q == TAG_VGA) && !rst;
  assign cpu_rdata  = mem_rdata;
  assign vga_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a one-cycle-latency memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        vga_req, vga_gnt, vga_rvalid;
  logic [15:0] vga_addr, vga_rdata;
  logic        usr_req, usr_gnt;
  logic [15:0] usr_addr, usr_wdata;
  logic        mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.WIDTH(16), .AWIDTH(16), .STARVE(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .usr_req(usr_req), .usr_addr(usr_addr), .usr_wdata(usr_wdata), .usr_gnt(usr_gnt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:0]];
  end

  // Advance to the next falling edge, where inputs change and outputs are sampled.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1'b1; vga_req = 1'b1; usr_req = 1'b1; cpu_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #1;
      checks++;
      if ({cpu_gnt, vga_gnt, usr_gnt, cpu_rvalid, vga_rvalid, mem_we} !== 6'b000000) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: gnt/rvalid/we=%b expected 000000", i,
                 {cpu_gnt, vga_gnt, usr_gnt, cpu_rvalid, vga_rvalid, mem_we});
      end
    end
    rst = 1'b0; vga_req = 1'b0;
    #1;
    checks++;
    if ({cpu_gnt, usr_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL reset_rr_cpu_first: cpu/usr gnt=%b expected 10", {cpu_gnt, usr_gnt});
    end
    next_cycle();
    cpu_req = 1'b0; usr_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || mem_addr !== 16'h0040 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_grant: gnt=%b addr=%h we=%b expected 1 0040 0", cpu_gnt, mem_addr, mem_we);
    end
    next_cycle();
    cpu_req = 1'b0;
    #1;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1234 || vga_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_data: rvalid=%b rdata=%h vga_rvalid=%b expected 1 1234 0",
               cpu_rvalid, cpu_rdata, vga_rvalid);
    end
    next_cycle();
  endtask

  // The cpu grant in test_cpu_read leaves the pointer on usr, so usr goes first.
  task automatic test_round_robin();
    logic exp_usr;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'haaaa;
    usr_req = 1'b1; usr_addr = 16'h0010; usr_wdata = 16'h0005;
    for (int i = 0; i < 6; i++) begin
      exp_usr = (i % 2 == 0);
      #1;
      checks++;
      if (usr_gnt !== exp_usr || cpu_gnt !== !exp_usr || vga_gnt !== 1'b0) begin
        errors++;
        $display("FAIL rr_grant cyc%0d: cpu/usr=%b%b expected %b%b", i, cpu_gnt, usr_gnt,
                 !exp_usr, exp_usr);
      end
      checks++;
      if (exp_usr && (mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 16'h0005)) begin
        errors++;
        $display("FAIL rr_usr_mux cyc%0d: we=%b addr=%h wdata=%h expected 1 0010 0005",
                 i, mem_we, mem_addr, mem_wdata);
      end else if (!exp_usr && (mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 16'haaaa)) begin
        errors++;
        $display("FAIL rr_cpu_mux cyc%0d: we=%b addr=%h wdata=%h expected 1 0020 aaaa",
                 i, mem_we, mem_addr, mem_wdata);
      end
      next_cycle();
    end
    cpu_req = 1'b0; usr_req = 1'b0; cpu_we = 1'b0;
    next_cycle();
  endtask

  task automatic test_vga_priority();
    vga_req = 1'b1; vga_addr = 16'h0100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    for (int c = 1; c <= 10; c++) begin
      #1;
      checks++;
      if (c == 9) begin
        if (cpu_gnt !== 1'b1 || vga_gnt !== 1'b0) begin
          errors++;
          $display("FAIL vga_prio_aged cyc%0d: cpu/vga=%b%b expected 10", c, cpu_gnt, vga_gnt);
        end
      end else if (cpu_gnt !== 1'b0 || vga_gnt !== 1'b1) begin
        errors++;
        $display("FAIL vga_prio cyc%0d: cpu/vga=%b%b expected 01", c, cpu_gnt, vga_gnt);
      end
      if (c == 10) begin
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1234) begin
          errors++;
          $display("FAIL vga_prio_cpu_return: rvalid=%b rdata=%h expected 1 1234", cpu_rvalid, cpu_rdata);
        end
      end
      next_cycle();
    end
    vga_req = 1'b0; cpu_req = 1'b0;
    next_cycle();
  endtask

  // Pointer sits on usr after the previous cpu grant, so usr wins the double-aged tie.
  task automatic test_double_aged();
    logic [2:0] exp;
    vga_req = 1'b1; vga_addr = 16'h0100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    usr_req = 1'b1; usr_addr = 16'h0011; usr_wdata = 16'h0007;
    for (int c = 1; c <= 11; c++) begin
      if (c == 9) exp = 3'b001;
      else if (c == 10) exp = 3'b100;
      else exp = 3'b010;
      #1;
      checks++;
      if ({cpu_gnt, vga_gnt, usr_gnt} !== exp) begin
        errors++;
        $display("FAIL double_aged cyc%0d: cpu/vga/usr=%b expected %b", c,
                 {cpu_gnt, vga_gnt, usr_gnt}, exp);
      end
      next_cycle();
    end
    vga_req = 1'b0; cpu_req = 1'b0; usr_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    vga_req = 1'b1; vga_addr = 16'h0100;
    #1;
    checks++;
    if (vga_gnt !== 1'b1 || mem_addr !== 16'h0100) begin
      errors++;
      $display("FAIL b2b_vga_grant: gnt=%b addr=%h expected 1 0100", vga_gnt, mem_addr);
    end
    next_cycle();
    vga_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0101;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || vga_rvalid !== 1'b1 || vga_rdata !== 16'hbeef || cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_vga_data: cpu_gnt=%b vga_rvalid=%b vga_rdata=%h cpu_rvalid=%b expected 1 1 beef 0",
               cpu_gnt, vga_rvalid, vga_rdata, cpu_rvalid);
    end
    next_cycle();
    cpu_req = 1'b0;
    #1;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hcafe || vga_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_cpu_data: rvalid=%b rdata=%h vga_rvalid=%b expected 1 cafe 0",
               cpu_rvalid, cpu_rdata, vga_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_mid_read_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    usr_req = 1'b1; usr_addr = 16'h0012; usr_wdata = 16'h0001;
    next_cycle();
    rst = 1'b1; vga_req = 1'b1;
    #1;
    checks++;
    if (cpu_rvalid !== 1'b0 || {cpu_gnt, vga_gnt, usr_gnt} !== 3'b000 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_drop: rvalid=%b gnt=%b we=%b expected 0 000 0",
               cpu_rvalid, {cpu_gnt, vga_gnt, usr_gnt}, mem_we);
    end
    next_cycle();
    #1;
    checks++;
    if (dut.u_cpu_age.count_q !== 8'd0 || dut.u_usr_age.count_q !== 8'd0 || cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_age: cpu_age=%0d usr_age=%0d rvalid=%b expected 0 0 0",
               dut.u_cpu_age.count_q, dut.u_usr_age.count_q, cpu_rvalid);
    end
    rst = 1'b0; cpu_req = 1'b0; vga_req = 1'b0; usr_req = 1'b0;
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[16'h0040] = 16'h1234;
    mem[16'h0100] = 16'hbeef;
    mem[16'h0101] = 16'hcafe;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    vga_req = 1'b0; vga_addr = 16'h0000;
    usr_req = 1'b0; usr_addr = 16'h0000; usr_wdata = 16'h0000;
    @(negedge clk);
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_vga_priority();
    test_double_aged();
    test_back_to_back();
    test_mid_read_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between three requesters:
  - the processor datapath (load/store);
  - the display glyph fetcher (read-only, real-time);
  - the user-input board updater (current/destination moves).
- Sits between those requesters and the data memory. Grants at most one access per cycle and steers read data back with a valid strobe.
- Display has priority. An aging guard prevents it from starving the processor or user port.

Parameters:
- WIDTH, 16, data width of every data bus.
- AWIDTH, 16, address width.
- STARVE, 8, consecutive cycles a waiting processor or user request may be denied before it overrides display priority (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-high.
- cpu_req  in  1  processor access request, held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AWIDTH  processor address.
- cpu_wdata  in  WIDTH  processor write data.
- cpu_gnt  out  1  processor granted this cycle.
- cpu_rvalid  out  1  processor read data valid.
- cpu_rdata  out  WIDTH  processor read data.
- vga_req  in  1  glyph read request.
- vga_addr  in  AWIDTH  glyph address.
- vga_gnt  out  1  glyph read granted this cycle.
- vga_rvalid  out  1  glyph data valid.
- vga_rdata  out  WIDTH  glyph data.
- usr_req  in  1  user-port write request.
- usr_addr  in  AWIDTH  board square address.
- usr_wdata  in  WIDTH  piece code to write.
- usr_gnt  out  1  user write granted this cycle.
- mem_we  out  1  memory write enable.
- mem_addr  out  AWIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data, valid one cycle after its address.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). On rst:
  - all gnt and rvalid outputs are 0 and mem_we is 0;
  - the round-robin pointer selects cpu;
  - both age counters are 0.
- Handshake:
  - A requester holds req and its request fields stable until it sees gnt high on a rising clock edge.
  - The access occurs in the gnt cycle.
  - Dropping req before gnt is legal and withdraws the request.
- Grant is combinational from the current req inputs plus registered state (rr pointer, age counters). Exactly zero or one gnt is high per cycle.
- Priority order in each cycle:
  1. Any of cpu/usr whose age counter equals STARVE wins over vga.
     - If both are aged, the rr pointer picks between them.
  2. Otherwise vga wins if it requests.
  3. Otherwise cpu and usr share round-robin. On a tie the rr pointer's side wins.
  4. After a cpu or usr grant, the rr pointer moves to the other side. The pointer is unchanged on a vga grant or an idle cycle.
- Age counters, one each for cpu and usr:
  - increment while the port requests and is not granted, saturating at STARVE;
  - clear on that port's grant or when its req is low.
- mem_addr/mem_we/mem_wdata are muxed combinationally from the granted port.
  - No grant: mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - mem_we = cpu_we for cpu, 0 for vga, 1 for usr.
- Read return:
  - A registered 2-bit return tag records the granted read source: none / cpu / vga.
  - Next cycle, exactly the matching rvalid is 1 for one cycle.
  - cpu_rdata and vga_rdata both equal mem_rdata; rvalid qualifies them.
  - Writes never produce rvalid.
- Latency: grant to read data is 1 cycle. Back-to-back grants to any mix of ports are allowed every cycle, giving full throughput.
- Boundary conditions:
  - rst asserted in the cycle after a read grant forces rvalid to 0, and the read data is dropped.
  - rst asserted together with requests grants nothing.
  - STARVE = 1 means any denied cpu/usr request beats vga on its next cycle.
  - Simultaneous aged cpu and usr with vga: cpu/usr win per the rr pointer. vga waits; it is never aged.

Decomposition:
- Shared package holds:
  - return-tag encodings (TAG_NONE = 0, TAG_CPU = 1, TAG_VGA = 2);
  - port index constants (cpu = 0, vga = 1, usr = 2).
- One natural sub-module: arb_age_counter, a saturating wait counter with inputs req, gnt and output aged. Instantiated twice.

Test Plan:
- Reset: hold rst 2 cycles with all req = 1 -> all gnt = 0, rvalid = 0, mem_we = 0. First cycle after rst with cpu_req and usr_req -> cpu_gnt = 1.
- CPU read: cpu_req = 1, cpu_we = 0, cpu_addr = 0x0040, memory holds 0x1234 -> cpu_gnt same cycle, mem_addr = 0x0040. Next cycle cpu_rvalid = 1, cpu_rdata = 0x1234, vga_rvalid = 0.
- Round-robin: cpu_req and usr_req held high, usr_addr = 0x0010, usr_wdata = 0x0005 -> grants alternate cpu, usr, cpu… On each usr cycle mem_we = 1, mem_addr = 0x0010, mem_wdata = 0x0005.
- Display priority: vga_req and cpu_req high together, STARVE = 8 -> vga_gnt for 8 cycles, cpu_gnt on cycle 9, vga_gnt again on cycle 10.
- Back-to-back: vga read 0x0100 then cpu read 0x0101 in consecutive cycles -> vga_rvalid then cpu_rvalid in consecutive cycles, each with its own word.
- Mid-read reset: cpu read granted, rst high the next cycle -> cpu_rvalid stays 0 and age counters read 0.
